keypad_bcd_entry: RTL

Input-side companion to the 3-digit BCD down-counter/seven-segment display path. Scans a 4x4 matrix keypad, debounces and encodes key presses, and assembles a 3-digit BCD preset. A one-cycle `load` strobe transfers the preset into the counter. Single clock domain; all slow timing is derived from an internal tick strobe, never from a generated clock.

---
 rtl/keypad_bcd_entry_pkg.sv | 23 ++
 rtl/keypad_bcd_entry_scan.sv | 123 ++++++++++++
 rtl/keypad_bcd_entry.sv | 82 ++++++++
 3 files changed

// File: rtl/keypad_bcd_entry_pkg.sv
// Shared types and constants for the keypad BCD preset entry path:
// scan FSM states, special key codes and the row/column-to-code map.
package keypad_bcd_entry_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEB,
    ST_HELD
  } scan_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] KEY_B    = 4'hB;

  // Indexed by {row, col}; entry 0 is row0/col0 ("1").
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/keypad_bcd_entry_scan.sv
// 4x4 keypad scanner: tick divider, column synchronizer, row rotation and
// press/release debounce. Emits a one-cycle key_valid with the key code.
module keypad_scan
  import keypad_bcd_entry_pkg::*;
#(
  parameter int SCAN_DIV       = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic       key_vld_p0,
  output logic [3:0] key_code_p0,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic [SCAN_DIV-1:0] div;
  logic                tick;
  logic [3:0]          col_p0, col_p1;
  scan_state_t         state, state_nxt;
  logic [1:0]          row_idx, row_idx_nxt;
  logic [1:0]          col_idx, col_idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [1:0]          col_first;
  logic                col_hit;

  assign tick    = &div;
  assign key_row = ~(4'b0001 << row_idx);
  assign col_hit = ~col_p1[col_idx];

  always_comb begin
    col_first = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_p1[i]) col_first = 2'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    col_idx_nxt = col_idx;
    cnt_nxt     = cnt;
    key_vld_p0  = 1'b0;
    if (tick) begin
      unique case (state)
        ST_SCAN: begin
          if (col_p1 == 4'hF) begin
            row_idx_nxt = row_idx + 2'd1;
          end else begin
            col_idx_nxt = col_first;
            if (DEBOUNCE_SCANS <= 1) begin
              key_vld_p0 = 1'b1;
              state_nxt  = ST_HELD;
              cnt_nxt    = '0;
            end else begin
              state_nxt = ST_DEB;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_DEB: begin
          if (!col_hit) begin
            state_nxt   = ST_SCAN;
            row_idx_nxt = row_idx + 2'd1;
          end else if (cnt + CNT_ONE == CNT_LAST) begin
            key_vld_p0 = 1'b1;
            state_nxt  = ST_HELD;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_HELD: begin
          // Release count restarts whenever the key reads low again.
          if (col_hit) begin
            cnt_nxt = '0;
          end else if (cnt + CNT_ONE == CNT_LAST) begin
            state_nxt   = ST_SCAN;
            row_idx_nxt = row_idx + 2'd1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

  assign key_code_p0 = KEY_MAP[{row_idx, col_idx_nxt}];

  // Stage p0 -> p1: synchronizer, FSM state and registered key strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div       <= '0;
      col_p0    <= 4'hF;
      col_p1    <= 4'hF;
      state     <= ST_SCAN;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      div       <= div + 1'b1;
      col_p0    <= key_col;
      col_p1    <= col_p0;
      state     <= state_nxt;
      row_idx   <= row_idx_nxt;
      col_idx   <= col_idx_nxt;
      cnt       <= cnt_nxt;
      key_valid <= key_vld_p0;
      if (key_vld_p0) key_code <= key_code_p0;
    end
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad BCD preset entry: 3-digit shift-in register with clear (*) and load (#).
// Define KEYPAD_BACKSPACE_EN to make key B delete the most recent digit.
module keypad_bcd_entry
  import keypad_bcd_entry_pkg::*;
#(
  parameter int SCAN_DIV       = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       load,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [1:0] entry_cnt
);

  logic       key_vld_p0;
  logic [3:0] key_code_p0;

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .key_col    (key_col),
    .key_row    (key_row),
    .key_vld_p0 (key_vld_p0),
    .key_code_p0(key_code_p0),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  // Stage p0 -> p1: key action lands on the same edge that raises key_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit2    <= 4'd0;
      digit1    <= 4'd0;
      digit0    <= 4'd0;
      entry_cnt <= 2'd0;
      load      <= 1'b0;
    end else begin
      load <= 1'b0;
      if (key_vld_p0) begin
        if (key_code_p0 <= 4'd9) begin
          if (entry_cnt == 2'd0) begin
            digit2 <= 4'd0;
            digit1 <= 4'd0;
          end else begin
            digit2 <= digit1;
            digit1 <= digit0;
          end
          digit0 <= key_code_p0;
          if (entry_cnt != 2'd3) entry_cnt <= entry_cnt + 2'd1;
        end else if (key_code_p0 == KEY_STAR) begin
          digit2    <= 4'd0;
          digit1    <= 4'd0;
          digit0    <= 4'd0;
          entry_cnt <= 2'd0;
        end else if (key_code_p0 == KEY_HASH) begin
          load      <= 1'b1;
          entry_cnt <= 2'd0;
        end else if (key_code_p0 == KEY_B) begin
`ifdef KEYPAD_BACKSPACE_EN
          if (entry_cnt != 2'd0) begin
            digit0    <= digit1;
            digit1    <= digit2;
            digit2    <= 4'd0;
            entry_cnt <= entry_cnt - 2'd1;
          end
`endif
        end
      end
    end
  end

endmodule
